// File: rtl/result_axis_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : result_axis_tx_pkg                                           |
// | Description : Shared sizes and FSM state encoding for the CNN result       |
// |               transmitter and its argmax helper.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package result_axis_tx_pkg;

  localparam int c_n_class = 10;  // FC2 output logits
  localparam int c_data_w  = 16;  // signed logit width, whole bytes
  localparam int c_idx_w   = 4;   // class-index width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARGMAX = 2'd1,
    SEND   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Frame length in bytes: every logit byte plus one trailing class byte.
  function automatic int frame_bytes(input int n_class, input int data_w);
    return n_class * (data_w / 8) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_axis_tx_argmax_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : argmax_seq                                                   |
// | Description : Sequential signed argmax, one compare per cycle. i_start     |
// |               loads element 0 as the running best; o_done pulses for one   |
// |               cycle once the last element has been compared. Ties keep     |
// |               the lower index.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module argmax_seq #(
  parameter int N_ELEM = 10,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [N_ELEM*DATA_W-1:0] i_vec,
  output logic                     o_done,
  output logic [IDX_W-1:0]         o_idx
);

  logic signed [DATA_W-1:0] r_best_val;
  logic [IDX_W-1:0]         r_best_idx;
  logic [IDX_W-1:0]         r_k;
  logic                     r_run;
  logic                     r_done;
  logic signed [DATA_W-1:0] w_cur;

  // Select the element under test this cycle.
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (r_k == IDX_W'(i)) w_cur = i_vec[i*DATA_W +: DATA_W];
    end
  end

  // Running best: strict greater-than so equal values keep the earlier index.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_best_val <= '0;
      r_best_idx <= '0;
      r_k        <= '0;
      r_run      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_best_val <= i_vec[DATA_W-1:0];
        r_best_idx <= '0;
        r_k        <= IDX_W'(1);
        r_run      <= 1'b1;
      end else if (r_run) begin
        if (w_cur > r_best_val) begin
          r_best_val <= w_cur;
          r_best_idx <= r_k;
        end
        if (r_k == IDX_W'(N_ELEM - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_idx  = r_best_idx;

endmodule
`default_nettype wire

// File: rtl/result_axis_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : result_axis_tx                                               |
// | Description : Captures an FC2 logit vector, finds the winning class and    |
// |               streams logits (little-endian, class order) followed by the  |
// |               class byte on an AXI-Stream byte master. Pulses o_intr once  |
// |               the frame has been accepted.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module result_axis_tx
  import result_axis_tx_pkg::*;
#(
  parameter int N_CLASS = c_n_class,
  parameter int DATA_W  = c_data_w,
  parameter int IDX_W   = c_idx_w
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [N_CLASS*DATA_W-1:0] i_data,
  output logic                      o_busy,
  output logic                      o_drop,
  output logic [7:0]                m_axis_data,
  output logic                      m_axis_valid,
  output logic                      m_axis_last,
  input  logic                      m_axis_ready,
  output logic [IDX_W-1:0]          o_class,
  output logic                      o_intr
);

  localparam int c_frame = frame_bytes(N_CLASS, DATA_W);
  localparam int c_cnt_w = $clog2(c_frame);
  localparam int c_last  = c_frame - 1;

  state_t                    r_state;
  logic [N_CLASS*DATA_W-1:0] r_vec;
  logic [c_cnt_w-1:0]        r_cnt;
  logic                      r_busy;
  logic                      r_drop;
  logic [7:0]                r_data;
  logic                      r_valid;
  logic                      r_last;
  logic [IDX_W-1:0]          r_class;
  logic                      r_intr;

  logic                      w_start;
  logic [N_CLASS*DATA_W-1:0] w_arg_vec;
  logic                      w_arg_done;
  logic [IDX_W-1:0]          w_arg_idx;
  logic [c_cnt_w-1:0]        w_sel;
  logic [7:0]                w_byte;

  // The argmax engine starts in the capture cycle, so it sees the live input
  // vector then and the captured copy afterwards.
  assign w_start   = (r_state == IDLE) && i_valid;
  assign w_arg_vec = (r_state == IDLE) ? i_data : r_vec;

  argmax_seq #(
    .N_ELEM (N_CLASS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_argmax (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_start),
    .i_vec   (w_arg_vec),
    .o_done  (w_arg_done),
    .o_idx   (w_arg_idx)
  );

  // Byte mux: the flattened vector is already class-ordered little-endian,
  // so byte i of the frame is simply byte i of the capture register.
  always_comb begin
    w_sel  = (r_state == SEND) ? r_cnt + 1'b1 : '0;
    w_byte = '0;
    for (int i = 0; i < c_last; i++) begin
      if (w_sel == c_cnt_w'(i)) w_byte = r_vec[i*8 +: 8];
    end
    if (w_sel == c_cnt_w'(c_last)) w_byte = 8'(r_class);
  end

  // Control FSM owning capture, class register, stream outputs and flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_class <= '0;
      r_intr  <= 1'b0;
    end else begin
      r_intr <= 1'b0;
      if (i_valid && (r_state != IDLE)) r_drop <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_vec   <= i_data;
            r_busy  <= 1'b1;
            r_state <= ARGMAX;
          end
        end
        ARGMAX: begin
          if (w_arg_done) begin
            r_class <= w_arg_idx;
            r_cnt   <= '0;
            r_data  <= w_byte;
            r_valid <= 1'b1;
            r_last  <= (c_last == 0);
            r_state <= SEND;
          end
        end
        SEND: begin
          if (r_valid && m_axis_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_busy  <= 1'b0;
              r_intr  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt  <= w_sel;
              r_data <= w_byte;
              r_last <= (w_sel == c_cnt_w'(c_last));
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_drop       = r_drop;
  assign m_axis_data  = r_data;
  assign m_axis_valid = r_valid;
  assign m_axis_last  = r_last;
  assign o_class      = r_class;
  assign o_intr       = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_result_axis_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_result_axis_tx                                            |
// | Description : Scoreboard bench for result_axis_tx. Stimulus pushes the     |
// |               expected frame bytes; a monitor pops and compares them on    |
// |               every stream handshake.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_result_axis_tx;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int IW = 4;
  localparam int FB = 21;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           i_valid = 1'b0;
  logic [N*W-1:0] i_data = '0;
  logic           busy, drop, intr;
  logic [7:0]     m_data;
  logic           m_valid, m_last;
  logic           m_ready = 1'b1;
  logic [IW-1:0]  cls;

  always #5 clk = ~clk;

  result_axis_tx dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_busy       (busy),
    .o_drop       (drop),
    .m_axis_data  (m_data),
    .m_axis_valid (m_valid),
    .m_axis_last  (m_last),
    .m_axis_ready (m_ready),
    .o_class      (cls),
    .o_intr       (intr)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0]    exp_q[$];   // {last, data}
  logic [IW-1:0] cls_q[$];
  bit  mon_en = 1'b0;
  int  xfer_cnt = 0;
  int  intr_cnt = 0;
  int  ready_mode = 0;
  int  ready_step = 0;

  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_lastsig = 1'b0, prev_last_x = 1'b0;
  logic [7:0] prev_data = '0;

  // Test-1 frame written out by hand.
  logic [7:0] t1_bytes [FB] = '{8'hFB, 8'hFF, 8'h03, 8'h00, 8'h64, 8'h00, 8'h80,
                                8'hFF, 8'h07, 8'h00, 8'h00, 8'h00, 8'h63, 8'h00,
                                8'h01, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h02};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input logic signed [W-1:0] l [N]);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = l[i];
    return v;
  endfunction

  task automatic push_t1();
    for (int i = 0; i < FB; i++) exp_q.push_back({(i == FB - 1), t1_bytes[i]});
    cls_q.push_back(IW'(2));
  endtask

  task automatic push_model(input logic [N*W-1:0] v, input logic [IW-1:0] c);
    for (int i = 0; i < 2 * N; i++) exp_q.push_back({1'b0, v[i*8 +: 8]});
    exp_q.push_back({1'b1, 4'h0, c});
    cls_q.push_back(c);
  endtask

  task automatic fire(input logic [N*W-1:0] v);
    @(posedge clk); #1;
    i_data  = v;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!intr && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no o_intr expected pulse", name);
    end
    @(negedge clk);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  // Downstream ready: always 1, or a 1,0,0,1 opener followed by random stalls.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) m_ready = 1'b1;
      else begin
        if (ready_step < 4) m_ready = pat[3 - ready_step];
        else                m_ready = 1'($urandom_range(0, 1));
        ready_step++;
      end
    end
  end

  // Monitor: hold-stability, interrupt timing and scoreboard pops.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_valid && !prev_ready) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, prev_data);
          check("hold_last", m_last, prev_lastsig);
        end
        if (intr || prev_last_x) check("intr_timing", intr, prev_last_x);
        if (intr) intr_cnt++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            check("byte_data", m_data, e[7:0]);
            check("byte_last", m_last, e[8]);
            if (m_last && cls_q.size() > 0) check("o_class_at_last", cls, cls_q.pop_front());
          end
          xfer_cnt++;
        end
        prev_last_x = m_valid && m_ready && m_last;
      end else begin
        prev_last_x = 1'b0;
      end
      prev_valid   = m_valid;
      prev_ready   = m_ready;
      prev_data    = m_data;
      prev_lastsig = m_last;
    end
  end

  initial begin
    logic signed [W-1:0] l [N];
    logic [N*W-1:0] v1, v2, v5, v6;
    int n, base;

    l  = '{-16'sd5, 16'sd3, 16'sd100, -16'sd128, 16'sd7, 16'sd0, 16'sd99, 16'sd1, 16'sd2, -16'sd1};
    v1 = pack(l);
    for (int i = 0; i < N; i++) l[i] = -16'sd1;
    l[1] = 16'sh7FFF;
    l[7] = 16'sh7FFF;
    v2 = pack(l);
    for (int i = 0; i < N; i++) l[i] = 16'sh8000;
    v6 = pack(l);
    l  = '{16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd50, -16'sd9, 16'sd4, 16'sd5, 16'sd6, 16'sd7};
    v5 = pack(l);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    check("rst_class", cls, 0);
    check("rst_intr", intr, 0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Test 1: mixed logits, ready held high, latency to first byte
    push_t1();
    fire(v1);
    check("t1_busy", busy, 1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!m_valid && n < 50);
    check("t1_first_valid_latency", n, 10);
    wait_done("t1");
    check("t1_class_held", cls, 2);
    check("t1_busy_after", busy, 0);

    // Test 2: tie between classes 1 and 7
    push_model(v2, IW'(1));
    fire(v2);
    wait_done("t2");
    check("t2_class", cls, 1);

    // Test 3: backpressure, same frame as test 1
    ready_step = 0;
    ready_mode = 1;
    push_t1();
    fire(v1);
    wait_done("t3");
    ready_mode = 0;
    check("t3_class", cls, 2);

    // Test 6: all logits at the most negative value
    push_model(v6, IW'(0));
    fire(v6);
    wait_done("t6");
    check("t6_class", cls, 0);

    // Test 4: overflow while busy
    base = intr_cnt;
    push_t1();
    fire(v1);
    repeat (3) @(posedge clk);
    fire(v2);
    check("t4_drop_set", drop, 1);
    wait_done("t4");
    repeat (30) @(negedge clk);
    check("t4_intr_count", intr_cnt - base, 1);
    check("t4_drop_sticky", drop, 1);

    // Test 5: reset mid-frame, then a fresh full frame
    base = xfer_cnt;
    push_model(v5, IW'(4));
    fire(v5);
    n = 0;
    while (xfer_cnt < base + 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_byte7", (xfer_cnt >= base + 7), 1);
    mon_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_last", m_last, 0);
    check("t5_rst_data", m_data, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_drop", drop, 0);
    check("t5_rst_class", cls, 0);
    check("t5_rst_intr", intr, 0);
    rst = 1'b1;
    exp_q.delete();
    cls_q.delete();
    mon_en = 1'b1;
    base = xfer_cnt;
    push_model(v5, IW'(4));
    fire(v5);
    wait_done("t5");
    check("t5_full_frame", xfer_cnt - base, FB);
    check("t5_class", cls, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
